memory_write: RTL and testbench
===============================

// Module: memory_write
// PURPOSE
//  Write-side counterpart of the memory read splitter; sits between the execute/write stage and the TLB write port.
//  Accepts a 1..8 byte write and issues one or two TLB write requests.
//  Issues two requests only when the access crosses a 16-byte line boundary.
//  Reports completion, page fault or alignment-check fault back to the requester.
// PARAMETERS
//  none; line size fixed at 16 bytes, max access 8 bytes
// PORTS
//  clk                 in   1   clock; single clock domain
//  rst                 in   1   asynchronous reset, active-high
//  wr_reset            in   1   pipeline flush: abandon current write
//  write_do            in   1   request; held high until write_done or fault
//  write_done          out  1   one-cycle completion pulse
//  write_page_fault    out  1   sticky page fault flag; cleared by wr_reset
//  write_ac_fault      out  1   sticky alignment-check fault flag; cleared by wr_reset
//  write_cpl           in   2   privilege level
//  write_address       in   32  linear address
//  write_length        in   4   byte count, 1..8
//  write_lock          in   1   locked cycle
//  write_rmw           in   1   read-modify-write cycle
//  write_data          in   64  data, byte 0 in [7:0]
//  tlbwrite_do         out  1   TLB request, held until done, fault or abort
//  tlbwrite_done       in   1   TLB completed current part
//  tlbwrite_page_fault in   1   TLB page fault
//  tlbwrite_ac_fault   in   1   TLB alignment-check fault
//  tlbwrite_retry      in   1   TLB may safely be abandoned this cycle
//  tlbwrite_cpl        out  2   = write_cpl
//  tlbwrite_address    out  32  address of current part
//  tlbwrite_length     out  4   bytes in current part
//  tlbwrite_length_full out 4   = write_length
//  tlbwrite_lock       out  1   = write_lock
//  tlbwrite_rmw        out  1   = write_rmw
//  tlbwrite_data       out  64  data of current part, LSB-aligned
// BEHAVIOUR
//  Reset values: state=IDLE; write_done, both fault flags and reset_waiting = 0.
//  Reset values: len2_reg, addr2_reg and data2_reg = 0.
//  Split arithmetic:
//   left = 16 - addr[3:0] (5 bits); len1 = (left >= len) ? len : left[3:0]; len2 = len - len1.
//   addr2 = {addr[31:4],4'd0} + 16.
//   data2 = write_data >> (8*len1), truncated to 56 bits.
//  IDLE:
//   - write_done <= 0 every cycle.
//   - Register len2, addr2 and data2 every cycle.
//   - Drive address=write_address, length=len1, data=write_data.
//   - If write_do & ~write_done & ~wr_reset & no fault flag set: assert tlbwrite_do, go to FIRST.
//  FIRST:
//   - tlbwrite_do=1; drive first-part address, length and data.
//   - On page/ac fault, or retry & reset_waiting: go to IDLE.
//   - Else on done with len2_reg!=0: go to SECOND.
//   - Else on done: go to IDLE; write_done <= 1 unless wr_reset | reset_waiting.
//  SECOND:
//   - tlbwrite_do=1; drive addr2_reg, len2_reg and {8'd0,data2_reg}.
//   - On fault, done, or retry & reset_waiting: go to IDLE.
//   - On done & ~wr_reset & ~reset_waiting: write_done <= 1.
//  Latency: min 1 cycle after tlbwrite_done, i.e. 2 cycles from write_do with a 0-wait TLB.
//  reset_waiting: set by wr_reset while state != IDLE; cleared in IDLE.
//   - The TLB request is never dropped mid-transaction except on retry.
//   - A completion arriving while reset_waiting is swallowed (no write_done).
//  Fault flags: set on the TLB fault only if ~reset_waiting; wr_reset clears and wins same cycle.
//  First part is committed if the second part faults; no rollback; fault reported.
//  Priority in FIRST/SECOND: fault > abort-on-retry > done.
//  Simultaneous wr_reset and tlbwrite_done: transaction completes silently.
//  write_length 0 or >8: undefined; the requester guarantees 1..8.
// CONFIGURATION
//  MEMORY_WRITE_SPLIT_COUNT_EN defined:
//   - Adds output split_count[15:0], reset 0.
//   - Increments on each FIRST->SECOND transition; wraps FFFF->0000.
//  MEMORY_WRITE_SPLIT_COUNT_EN not defined: the port and counter are absent; behaviour otherwise identical.
// TESTING
//  1. addr=0x1000, len=4, data=0x11223344, TLB done next cycle:
//     -> one request, len 4; write_done pulse 1 cycle; no SECOND.
//  2. addr=0x100E, len=4, data=0xAABBCCDD:
//     -> part 1 addr 0x100E len 2 data ..CCDD; part 2 addr 0x1010 len 2 data 0xAABB; single write_done.
//  3. addr=0x100F, len=8: SECOND gets page fault
//     -> write_page_fault=1, no write_done, state IDLE; held write_do not reissued until wr_reset.
//  4. wr_reset during FIRST, retry=0, then done:
//     -> no write_done, no fault flag set; then idle and accept the next write.
//  5. wr_reset during SECOND with retry=1:
//     -> IDLE next cycle; tlbwrite_do drops.
//  6. With MEMORY_WRITE_SPLIT_COUNT_EN: 3 line-crossing writes + 2 aligned writes -> split_count=3.

Source files
------------

// File: rtl/memory_write.sv
// rtl/memory_write.sv - write splitter: one 1..8 byte write into one or two TLB line-bounded parts (optional MEMORY_WRITE_SPLIT_COUNT_EN adds split_count)
module memory_write (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_reset,
  input  logic        write_do,
  output logic        write_done,
  output logic        write_page_fault,
  output logic        write_ac_fault,
  input  logic [1:0]  write_cpl,
  input  logic [31:0] write_address,
  input  logic [3:0]  write_length,
  input  logic        write_lock,
  input  logic        write_rmw,
  input  logic [63:0] write_data,
  output logic        tlbwrite_do,
  input  logic        tlbwrite_done,
  input  logic        tlbwrite_page_fault,
  input  logic        tlbwrite_ac_fault,
  input  logic        tlbwrite_retry,
  output logic [1:0]  tlbwrite_cpl,
  output logic [31:0] tlbwrite_address,
  output logic [3:0]  tlbwrite_length,
  output logic [3:0]  tlbwrite_length_full,
  output logic        tlbwrite_lock,
  output logic        tlbwrite_rmw,
  output logic [63:0] tlbwrite_data
`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
  ,
  output logic [15:0] split_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  logic [1:0]  r_state;
  logic        r_write_done;
  logic        r_page_fault;
  logic        r_ac_fault;
  logic        r_reset_waiting;
  logic [3:0]  r_len2;
  logic [31:0] r_addr2;
  logic [55:0] r_data2;

  logic [4:0]  w_left;
  logic [3:0]  w_len1;
  logic [3:0]  w_len2;
  logic [31:0] w_addr2;
  logic [55:0] w_data2;
  logic        w_busy;
  logic        w_start;
  logic        w_fault;
  logic        w_abort;
  logic        w_to_second;

  // Bytes left in the current 16-byte line decide how much fits in the first part
  assign w_left  = 5'd16 - {1'b0, write_address[3:0]};
  assign w_len1  = (w_left >= {1'b0, write_length}) ? write_length : w_left[3:0];
  assign w_len2  = write_length - w_len1;
  assign w_addr2 = {write_address[31:4], 4'd0} + 32'd16;
  assign w_data2 = 56'(write_data >> {w_len1, 3'b000});

  // A new write is refused while a done pulse is out or a fault is still latched
  assign w_busy      = (r_state != ST_IDLE);
  assign w_start     = (r_state == ST_IDLE) & write_do & ~r_write_done & ~wr_reset
                       & ~r_page_fault & ~r_ac_fault;
  assign w_fault     = tlbwrite_page_fault | tlbwrite_ac_fault;
  assign w_abort     = tlbwrite_retry & r_reset_waiting;
  assign w_to_second = (r_state == ST_FIRST) & ~w_fault & ~w_abort & tlbwrite_done
                       & (r_len2 != 4'd0);

  assign write_done           = r_write_done;
  assign write_page_fault     = r_page_fault;
  assign write_ac_fault       = r_ac_fault;
  assign tlbwrite_do          = w_start | w_busy;
  assign tlbwrite_cpl         = write_cpl;
  assign tlbwrite_length_full = write_length;
  assign tlbwrite_lock        = write_lock;
  assign tlbwrite_rmw         = write_rmw;
  assign tlbwrite_address     = (r_state == ST_SECOND) ? r_addr2 : write_address;
  assign tlbwrite_length      = (r_state == ST_SECOND) ? r_len2  : w_len1;
  assign tlbwrite_data        = (r_state == ST_SECOND) ? {8'd0, r_data2} : write_data;

  // Main sequencer: IDLE captures the second-part split, FIRST/SECOND track TLB replies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_write_done <= 1'b0;
      r_len2       <= 4'd0;
      r_addr2      <= 32'd0;
      r_data2      <= 56'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_write_done <= 1'b0;
          r_len2       <= w_len2;
          r_addr2      <= w_addr2;
          r_data2      <= w_data2;
          if (w_start) r_state <= ST_FIRST;
        end
        ST_FIRST: begin
          if (w_fault || w_abort) begin
            r_state <= ST_IDLE;
          end else if (tlbwrite_done && r_len2 != 4'd0) begin
            r_state <= ST_SECOND;
          end else if (tlbwrite_done) begin
            r_state      <= ST_IDLE;
            r_write_done <= ~(wr_reset | r_reset_waiting);
          end
        end
        ST_SECOND: begin
          if (w_fault || w_abort) begin
            r_state <= ST_IDLE;
          end else if (tlbwrite_done) begin
            r_state      <= ST_IDLE;
            r_write_done <= ~(wr_reset | r_reset_waiting);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A flush seen mid-transaction is remembered until the sequencer gets back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reset_waiting <= 1'b0;
    end else if (wr_reset && w_busy) begin
      r_reset_waiting <= 1'b1;
    end else if (!w_busy) begin
      r_reset_waiting <= 1'b0;
    end
  end

  // Sticky fault flags; a flush clears them and beats a same-cycle fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page_fault <= 1'b0;
      r_ac_fault   <= 1'b0;
    end else if (wr_reset) begin
      r_page_fault <= 1'b0;
      r_ac_fault   <= 1'b0;
    end else if (w_busy && !r_reset_waiting) begin
      if (tlbwrite_page_fault) r_page_fault <= 1'b1;
      if (tlbwrite_ac_fault)   r_ac_fault   <= 1'b1;
    end
  end

`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
  // Counts line-crossing writes whose first part went through; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_count <= 16'd0;
    end else if (w_to_second) begin
      split_count <= split_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_write.sv
// tb/tb_memory_write.sv - scoreboard bench for memory_write with a randomised TLB responder
module tb_memory_write;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_reset;
  logic        write_do;
  logic        write_done;
  logic        write_page_fault;
  logic        write_ac_fault;
  logic [1:0]  write_cpl;
  logic [31:0] write_address;
  logic [3:0]  write_length;
  logic        write_lock;
  logic        write_rmw;
  logic [63:0] write_data;
  logic        tlbwrite_do;
  logic        tlbwrite_done;
  logic        tlbwrite_page_fault;
  logic        tlbwrite_ac_fault;
  logic        tlbwrite_retry;
  logic [1:0]  tlbwrite_cpl;
  logic [31:0] tlbwrite_address;
  logic [3:0]  tlbwrite_length;
  logic [3:0]  tlbwrite_length_full;
  logic        tlbwrite_lock;
  logic        tlbwrite_rmw;
  logic [63:0] tlbwrite_data;
`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
  logic [15:0] split_count;
`endif

  memory_write dut (
    .clk(clk), .rst(rst), .wr_reset(wr_reset), .write_do(write_do),
    .write_done(write_done), .write_page_fault(write_page_fault),
    .write_ac_fault(write_ac_fault), .write_cpl(write_cpl),
    .write_address(write_address), .write_length(write_length),
    .write_lock(write_lock), .write_rmw(write_rmw), .write_data(write_data),
    .tlbwrite_do(tlbwrite_do), .tlbwrite_done(tlbwrite_done),
    .tlbwrite_page_fault(tlbwrite_page_fault), .tlbwrite_ac_fault(tlbwrite_ac_fault),
    .tlbwrite_retry(tlbwrite_retry), .tlbwrite_cpl(tlbwrite_cpl),
    .tlbwrite_address(tlbwrite_address), .tlbwrite_length(tlbwrite_length),
    .tlbwrite_length_full(tlbwrite_length_full), .tlbwrite_lock(tlbwrite_lock),
    .tlbwrite_rmw(tlbwrite_rmw), .tlbwrite_data(tlbwrite_data)
`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
    , .split_count(split_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic [3:0]  full;
    logic [1:0]  cpl;
    logic        lock;
    logic        rmw;
  } part_t;

  part_t exp_parts[$];
  int    exp_done_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_splits = 0;
  int    last_cross = 0;

  // responder controls
  int part_cnt = 0;
  int wait_cnt = 0;
  int hold_at = -1;
  int fault_at = -1;
  int fault_kind = 0;
  int rand_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] byte_mask(input int len);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < len; k++) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // TLB model: replies after a random wait, one part per reply, fault on a chosen part
  initial begin
    tlbwrite_done = 0; tlbwrite_page_fault = 0; tlbwrite_ac_fault = 0;
    forever begin
      @(posedge clk); #1;
      tlbwrite_done = 0; tlbwrite_page_fault = 0; tlbwrite_ac_fault = 0;
      if (!rst && tlbwrite_do && part_cnt != hold_at) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          if (part_cnt == fault_at) begin
            if (fault_kind == 0) tlbwrite_page_fault = 1;
            else tlbwrite_ac_fault = 1;
          end else tlbwrite_done = 1;
          part_cnt++;
          wait_cnt = rand_wait ? $urandom_range(0, 2) : 0;
        end
      end
    end
  end

  // Monitor: pops expected parts on each TLB reply and expected completions on write_done
  initial begin
    part_t p;
    logic prev_done;
    prev_done = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin prev_done = 0; continue; end
      if (tlbwrite_do && (tlbwrite_done || tlbwrite_page_fault || tlbwrite_ac_fault)) begin
        chk("tlb_part_expected", 64'(exp_parts.size() > 0), 64'd1);
        if (exp_parts.size() > 0) begin
          p = exp_parts.pop_front();
          chk("part_addr", tlbwrite_address, p.addr);
          chk("part_len", tlbwrite_length, p.len);
          chk("part_data", tlbwrite_data & byte_mask(int'(p.len)), p.data);
          chk("part_len_full", tlbwrite_length_full, p.full);
          chk("part_cpl", tlbwrite_cpl, p.cpl);
          chk("part_lock_rmw", {tlbwrite_lock, tlbwrite_rmw}, {p.lock, p.rmw});
        end
      end
      if (write_done) begin
        chk("done_single_pulse", prev_done, 0);
        chk("write_done_expected", 64'(exp_done_q.size() > 0), 64'd1);
        if (exp_done_q.size() > 0) void'(exp_done_q.pop_front());
      end
      prev_done = write_done;
    end
  end

  // Reference split: bytes up to the line end go first, the rest go to the next line
  task automatic setup(input logic [31:0] a, input int len, input logic [63:0] d, input int max_parts);
    part_t p;
    int n1;
    n1 = 16 - int'(a[3:0]);
    if (n1 > len) n1 = len;
    last_cross = (len > n1) ? 1 : 0;
    p.full = len[3:0];
    p.cpl  = 2'($urandom_range(0, 3));
    p.lock = 1'($urandom_range(0, 1));
    p.rmw  = 1'($urandom_range(0, 1));
    p.addr = a; p.len = n1[3:0]; p.data = '0;
    for (int k = 0; k < n1; k++) p.data[8*k +: 8] = d[8*k +: 8];
    if (max_parts >= 1) exp_parts.push_back(p);
    if (len > n1 && max_parts >= 2) begin
      p.addr = a + 32'(n1); p.len = 4'(len - n1); p.data = '0;
      for (int k = 0; k < len - n1; k++) p.data[8*k +: 8] = d[8*(n1 + k) +: 8];
      exp_parts.push_back(p);
    end
    write_address = a; write_length = len[3:0]; write_data = d;
    write_cpl = p.cpl; write_lock = p.lock; write_rmw = p.rmw;
    part_cnt = 0;
    wait_cnt = rand_wait ? $urandom_range(0, 2) : 0;
  endtask

  task automatic queues_drained(input string name);
    chk({name, "_parts_left"}, exp_parts.size(), 0);
    chk({name, "_done_left"}, exp_done_q.size(), 0);
    exp_parts.delete();
    exp_done_q.delete();
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [63:0] d,
                          input int f_at, input int f_kind, input int want_lat);
    int lat;
    bit seen;
    @(negedge clk);
    fault_at = f_at; fault_kind = f_kind; hold_at = -1;
    setup(a, len, d, (f_at == 0) ? 1 : 2);
    if (f_at < 0) exp_done_q.push_back(1);
    if (last_cross != 0 && f_at != 0) exp_splits++;
    write_do = 1;
    seen = 0; lat = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk); #2;
      lat++;
      if (write_done || write_page_fault || write_ac_fault) seen = 1;
    end
    if (write_done) write_do = 0;
    chk("write_finished_in_time", seen, 1);
    if (want_lat > 0) chk("write_latency", lat, want_lat);
    chk("write_done_outcome", write_done, (f_at < 0) ? 1 : 0);
    chk("page_fault_flag", write_page_fault, (f_at >= 0 && f_kind == 0) ? 1 : 0);
    chk("ac_fault_flag", write_ac_fault, (f_at >= 0 && f_kind != 0) ? 1 : 0);
    if (f_at >= 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #2;
        chk("no_reissue_after_fault", tlbwrite_do, 0);
      end
      @(negedge clk); wr_reset = 1; write_do = 0;
      @(negedge clk); wr_reset = 0; #2;
      chk("faults_cleared_by_flush", {write_page_fault, write_ac_fault}, 2'b00);
    end
    repeat (2) @(negedge clk);
    queues_drained("write");
    fault_at = -1;
  endtask

  initial begin
    int to;
    bit got_done;
    rst = 1; wr_reset = 0; write_do = 0; tlbwrite_retry = 0;
    write_cpl = 0; write_address = 0; write_length = 1; write_lock = 0;
    write_rmw = 0; write_data = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_done", write_done, 0);
    chk("reset_faults", {write_page_fault, write_ac_fault}, 2'b00);
    chk("reset_tlb_do", tlbwrite_do, 0);
`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
    chk("reset_split_count", split_count, 0);
`endif
    rst = 0;

    // 1: aligned single-part write, zero-wait TLB
    rand_wait = 0;
    do_write(32'h0000_1000, 4, 64'h11223344, -1, 0, 2);
    // 2: crossing write split 2+2
    do_write(32'h0000_100E, 4, 64'hAABBCCDD, -1, 0, 0);
    // 3: crossing write, page fault on second part
    do_write(32'h0000_100F, 8, 64'h0102030405060708, 1, 0, 0);

    // 4: flush during FIRST, completion afterwards is swallowed
    @(negedge clk);
    hold_at = 0; fault_at = -1;
    setup(32'h0000_2000, 4, 64'h55667788, 1);
    write_do = 1;
    @(negedge clk); #2;
    chk("t4_request_up", tlbwrite_do, 1);
    @(negedge clk); wr_reset = 1; write_do = 0;
    @(negedge clk); wr_reset = 0; hold_at = -1;
    got_done = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (write_done) got_done = 1;
    end
    chk("t4_no_write_done", got_done, 0);
    chk("t4_no_fault", {write_page_fault, write_ac_fault}, 2'b00);
    chk("t4_idle", tlbwrite_do, 0);
    queues_drained("t4");
    do_write(32'h0000_2040, 3, 64'h00C0FFEE, -1, 0, 0);

    // 5: flush during SECOND, then retry abandons the request
    @(negedge clk);
    hold_at = 1; fault_at = -1;
    setup(32'h0000_300C, 8, 64'hDEADBEEF_CAFEF00D, 1);
    exp_splits++;
    write_do = 1;
    to = 0;
    do begin
      @(negedge clk); #2;
      to++;
    end while (!(tlbwrite_do && tlbwrite_address == 32'h0000_3010) && to < 40);
    chk("t5_reached_second", tlbwrite_address, 32'h0000_3010);
    @(negedge clk); wr_reset = 1; write_do = 0;
    @(negedge clk); wr_reset = 0; tlbwrite_retry = 1; #2;
    chk("t5_held_until_retry", tlbwrite_do, 1);
    @(negedge clk); tlbwrite_retry = 0; #2;
    chk("t5_request_dropped", tlbwrite_do, 0);
    chk("t5_no_fault", {write_page_fault, write_ac_fault}, 2'b00);
    chk("t5_no_done", write_done, 0);
    hold_at = -1;
    repeat (2) @(negedge clk);
    queues_drained("t5");

    // random traffic with random TLB waits and occasional faults
    rand_wait = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int len, f_at, n1;
      a = $urandom;
      len = $urandom_range(1, 8);
      n1 = 16 - int'(a[3:0]);
      f_at = -1;
      if ($urandom_range(0, 4) == 0) f_at = (len > n1) ? $urandom_range(0, 1) : 0;
      do_write(a, len, {$urandom, $urandom}, f_at, $urandom_range(0, 1), 0);
    end

`ifdef MEMORY_WRITE_SPLIT_COUNT_EN
    chk("split_count", split_count, 64'(exp_splits));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
